// File: rtl/nios_system_cpu_debug_scan_master_pkg.sv
// Shared debug definitions: scan-master state encoding, virtual IR codes
// and the default scan data register length used by the debug-slave blocks.
package nios_system_cpu_debug_scan_master_pkg;

  localparam int DEFAULT_SR_WIDTH = 38;
  localparam int DEFAULT_TCK_DIV  = 2;

  // Virtual IR codes selecting the debug-slave data register.
  localparam logic [1:0] IR_MONITOR = 2'b00;
  localparam logic [1:0] IR_BREAK   = 2'b01;
  localparam logic [1:0] IR_TRACE   = 2'b10;
  localparam logic [1:0] IR_DEBUG   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RESP = 3'd5
  } scan_state_t;

  // True in the states that drive vji_tck (a scan is on the wire).
  function automatic logic scan_active(scan_state_t s);
    return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) || (s == ST_UDR);
  endfunction

endpackage

// File: rtl/nios_system_cpu_debug_scan_master_if.sv
// Command/response handshake bundle of the debug scan master.
//
// Handshake rule for both channels: a transfer happens on the rising clk
// edge where valid and ready are both high; the producer holds valid and its
// payload stable until that edge, and ready may be high without valid.
// The master modport is the scan engine; the slave modport is its requester.
interface nios_system_cpu_debug_scan_master_if #(
  parameter int SR_WIDTH = nios_system_cpu_debug_scan_master_pkg::DEFAULT_SR_WIDTH
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic                resp_valid;
  logic                resp_ready;
  logic [SR_WIDTH-1:0] resp_data;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, resp_ready,
    output cmd_ready, resp_valid, resp_data
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, resp_ready,
    input  cmd_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/nios_system_cpu_debug_scan_master_tckgen.sv
// vji_tck generator: one tck period is 2*TCK_DIV clk cycles, low for the
// first half and high for the second. The counter sits at zero whenever the
// generator is disabled, so every scan starts on a fresh period.
module nios_system_cpu_debug_scan_master_tckgen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic period_end
);
  localparam int            CW   = $clog2(2 * TCK_DIV);
  localparam logic [CW-1:0] HALF = CW'(TCK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);

  logic [CW-1:0] cnt;

  // Period counter: wraps at the end of each period, parked at zero when idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tck        = en && (cnt >= HALF);
  assign rise       = en && (cnt == HALF);
  assign period_end = en && (cnt == LAST);

endmodule

// File: rtl/nios_system_cpu_debug_scan_master.sv
// Virtual-JTAG scan master: per accepted command it walks UIR, CDR, SDR and
// UDR, shifting cmd_data out LSB first on vji_tdi while capturing vji_tdo,
// then offers the captured word as a response.
module nios_system_cpu_debug_scan_master
  import nios_system_cpu_debug_scan_master_pkg::*;
#(
  parameter int TCK_DIV  = DEFAULT_TCK_DIV,
  parameter int SR_WIDTH = DEFAULT_SR_WIDTH
) (
  input  logic        clk,
  input  logic        reset_n,
  nios_system_cpu_debug_scan_master_if.master bus,
  output logic        vji_tck,
  output logic        vji_tdi,
  output logic        vji_uir,
  output logic        vji_cdr,
  output logic        vji_sdr,
  output logic        vji_udr,
  output logic        vji_rti,
  output logic [1:0]  vji_ir_in,
  input  logic        vji_tdo,
  output scan_state_t dbg_state
);
  localparam int            BW       = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(SR_WIDTH - 1);

  scan_state_t         state;
  logic                cmd_ready_q;
  logic                resp_valid_q;
  logic [SR_WIDTH-1:0] shreg;
  logic [SR_WIDTH-1:0] capture;
  logic [BW-1:0]       bit_cnt;
  logic                rise;
  logic                period_end;

  nios_system_cpu_debug_scan_master_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (scan_active(state)),
    .tck        (vji_tck),
    .rise       (rise),
    .period_end (period_end)
  );

  // Scan sequencer; every vji strobe is registered alongside its state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      capture      <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      vji_ir_in    <= 2'b00;
      vji_tdi      <= 1'b0;
      vji_uir      <= 1'b0;
      vji_cdr      <= 1'b0;
      vji_sdr      <= 1'b0;
      vji_udr      <= 1'b0;
      vji_rti      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            vji_ir_in   <= bus.cmd_ir;
            shreg       <= bus.cmd_data;
            cmd_ready_q <= 1'b0;
            vji_rti     <= 1'b0;
            vji_uir     <= 1'b1;
            state       <= ST_UIR;
          end
        end
        ST_UIR: begin
          if (period_end) begin
            vji_uir <= 1'b0;
            vji_cdr <= 1'b1;
            state   <= ST_CDR;
          end
        end
        ST_CDR: begin
          if (period_end) begin
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b1;
            vji_tdi <= shreg[0];
            bit_cnt <= '0;
            state   <= ST_SDR;
          end
        end
        ST_SDR: begin
          // After SR_WIDTH right-shifts the first sample lands in bit 0.
          if (rise) begin
            capture <= {vji_tdo, capture[SR_WIDTH-1:1]};
          end
          if (period_end) begin
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_BIT) begin
              vji_sdr <= 1'b0;
              vji_tdi <= 1'b0;
              vji_udr <= 1'b1;
              state   <= ST_UDR;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              vji_tdi <= shreg[1];
            end
          end
        end
        ST_UDR: begin
          if (period_end) begin
            vji_udr      <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Return to IDLE only; the next command is taken a cycle later.
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            vji_rti      <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = capture;
  assign dbg_state      = state;

endmodule

// File: doc/nios_system_cpu_debug_scan_master.md
NIOS_SYSTEM_CPU_DEBUG_SCAN_MASTER -- requirements
Module: nios_system_cpu_debug_scan_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning clk cycles per vji_tck half-period (legal range 1..255).
REQ-002 SHALL have parameter SR_WIDTH, default 38, meaning scan data register length in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset; one clock domain only.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_ir  input  2  virtual IR value for the scan.
REQ-008 SHALL have port cmd_data  input  SR_WIDTH  data shifted out on vji_tdi.
REQ-009 SHALL have port resp_valid  output  1  capture data available.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-011 SHALL have port resp_data  output  SR_WIDTH  bits captured from vji_tdo.
REQ-012 SHALL have ports vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  output  1 each  virtual JTAG drive signals.
REQ-013 SHALL have port vji_ir_in  output  2  virtual IR value.
REQ-014 SHALL have port vji_tdo  input  1  serial data returned by the debug slave.

Function
REQ-015 SHALL implement states IDLE, UIR, CDR, SDR, UDR, RESP.
REQ-016 SHALL define a "tck period" as 2*TCK_DIV clk cycles: vji_tck low for the first TCK_DIV cycles, high for the last TCK_DIV cycles.
REQ-017 SHALL hold vji_tck low in IDLE and RESP, and restart the period counter on entry to UIR.
REQ-018 SHALL assert cmd_ready only in IDLE, and move to UIR on the cycle after acceptance.
REQ-019 SHALL latch cmd_ir into vji_ir_in and cmd_data into an internal shift register on acceptance, and hold vji_ir_in until the next acceptance.
REQ-020 SHALL assert vji_uir for exactly one tck period in UIR, then go to CDR.
REQ-021 SHALL assert vji_cdr for exactly one tck period in CDR, then go to SDR.
REQ-022 SHALL assert vji_sdr for exactly SR_WIDTH tck periods in SDR, then go to UDR.
REQ-023 SHALL drive vji_tdi with shift-register bit 0 (LSB first) from the start of each SDR period.
REQ-024 SHALL sample vji_tdo on the clk cycle on which vji_tck rises, placing the k-th sample (k = 0..SR_WIDTH-1) in resp_data[k].
REQ-025 SHALL shift the outgoing register right by one bit at the end of each SDR period.
REQ-026 SHALL drive vji_tdi to 0 outside SDR.
REQ-027 SHALL assert vji_udr for exactly one tck period in UDR, then go to RESP.
REQ-028 SHALL assert resp_valid in RESP and keep resp_data stable until resp_ready is sampled high, then return to IDLE.
REQ-029 SHALL NOT accept a new command on the cycle resp_ready completes (cmd_ready rises one cycle later, in IDLE).
REQ-030 SHALL assert vji_rti only in IDLE.
REQ-031 SHALL have exactly one of vji_uir/vji_cdr/vji_sdr/vji_udr/vji_rti high in states IDLE..UDR (mutually one-hot); all five are low in RESP.
REQ-032 SHALL give latency from acceptance to resp_valid high of 1 + 2*TCK_DIV*(SR_WIDTH+3) clk cycles (165 at defaults).
REQ-033 SHALL ignore cmd_valid while not in IDLE; a held command SHALL be accepted on the next IDLE cycle.

Reset
REQ-034 SHALL, on a clk edge with reset_n low, force state IDLE, cmd_ready=1, resp_valid=0, resp_data=0, vji_ir_in=0, shift register=0, period counter=0, vji_tck=0, vji_tdi=0, vji_uir/cdr/sdr/udr=0 and vji_rti=1.
REQ-035 SHALL abort any scan in progress on reset, produce no response for it, and emit no vji_udr pulse.

Structure
REQ-036 SHALL place the state enumeration, the IR code constants (2 bits), and the default SR_WIDTH in the shared debug package used by the debug-slave blocks.
REQ-037 SHALL use one sub-module, nios_system_cpu_debug_scan_master_tckgen: period counter, vji_tck, and rise/period-end strobes.

Verification
REQ-038 Bench SHALL check: cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA, slave loopback tdo=tdi -> resp_data=38'h2A_5555_AAAA, resp_valid 165 cycles after acceptance.
REQ-039 Bench SHALL check: tdo tied 1, any command -> resp_data=38'h3F_FFFF_FFFF; exactly 38 vji_tck rising edges with vji_sdr high; exactly 1 vji_uir period, 1 vji_cdr period and 1 vji_udr period, in that order.
REQ-040 Bench SHALL check: TCK_DIV=1 -> vji_tck toggles every clk cycle during a scan; latency = 83 cycles.
REQ-041 Bench SHALL check: resp_ready held low for 20 cycles -> resp_valid and resp_data stable; cmd_ready=0 throughout; cmd_ready=1 on the cycle after the resp_ready handshake.
REQ-042 Bench SHALL check: reset_n pulsed low at the 10th SDR period -> the next cycle shows IDLE outputs per REQ-034, no vji_udr and no resp_valid; a following command completes normally.
REQ-043 Bench SHALL check: cmd_valid held high back-to-back with two commands -> two complete scans separated by at least one IDLE cycle with vji_rti=1.
